mfp_ahb_interconnect: RTL and testbench
=======================================

// Module: mfp_ahb_interconnect
// PURPOSE
//  Parametrised AHB-lite interconnect: address decoder, registered data-phase select, HRDATA/HREADY/HRESP mux.
//  Sits between the MIPS core AHB master and N_SLAVES slaves (boot RAM, program RAM, GPIO, display, ...).
//  Honours slave wait states (HREADYOUT).
//  Contains a built-in default slave that returns a two-cycle ERROR for unmapped accesses.
//  Logs decode misses (count and last address) for debug.
// PARAMETERS
//  N_SLAVES   4             number of slaves (1..16)
//  SLV_BASE   {N_SLAVES{32'h0}}  packed N_SLAVES*32; slice i = match value for slave i
//  SLV_MASK   {N_SLAVES{32'h0}}  packed N_SLAVES*32; slice i = address bits compared for slave i
//  ERRCNT_W   16            width of decode-miss counter
// PORTS
//  HCLK        in   1            bus clock
//  HRESETn     in   1            asynchronous active-low reset
//  HADDR       in   32           master address (address phase)
//  HTRANS      in   2            master transfer type
//  HWRITE      in   1            master write flag
//  HRDATA      out  32           read data to master (data phase)
//  HREADY      out  1            transfer-done to master; also broadcast to slaves as HREADY
//  HRESP       out  1            response to master (0 OKAY, 1 ERROR)
//  HSEL        out  N_SLAVES     one-hot slave select (address phase, combinational)
//  HRDATA_S    in   N_SLAVES*32  slave read data, slice i from slave i
//  HREADYOUT_S in   N_SLAVES     slave ready outputs
//  HRESP_S     in   N_SLAVES     slave responses
//  err_count   out  ERRCNT_W     saturating count of unmapped NONSEQ/SEQ transfers
//  err_addr    out  32           HADDR of most recent unmapped transfer
// BEHAVIOUR
//  Decode (combinational):
//  - match_i = ((HADDR & SLV_MASK_i) == SLV_BASE_i).
//  - Lowest index wins on overlap.
//  - HSEL is one-hot or all-zero.
//  - No match -> default slave selected internally; HSEL = 0.
//  Data-phase select dsel (N_SLAVES+1 one-hot incl. default; plus "none"):
//  - Loads the decode result only when HREADY=1; holds while HREADY=0.
//  - Loads "none" when HTRANS[1]=0 (IDLE/BUSY).
//  Mux:
//  - HRDATA/HREADY/HRESP come from the slave in dsel.
//  - dsel=none -> HRDATA=0, HREADY=1, HRESP=0.
//  - HRDATA is 0 when the default slave is selected.
//  Default-slave FSM (IDLE, ERR1, ERR2):
//  - IDLE -> ERR1 when HREADY=1 and HTRANS[1]=1 and there is no match.
//  - ERR1: HREADY=0, HRESP=1; always -> ERR2.
//  - ERR2: HREADY=1, HRESP=1.
//    - -> ERR1 if another unmapped NONSEQ/SEQ is accepted this cycle.
//    - Otherwise -> IDLE.
//    - A mapped access accepted in ERR2 loads dsel normally.
//  - IDLE/BUSY to an unmapped address: no error, zero-wait OKAY.
//  Miss log (on each IDLE->ERR1 or ERR2->ERR1 entry):
//  - err_addr <= HADDR.
//  - err_count <= err_count+1, saturating at all-ones.
//  Latency:
//  - Decode is 0 cycles.
//  - Response appears in the cycle after the address phase.
//  - Extended by slave wait states; no added interconnect wait.
//  Reset (async, HRESETn=0):
//  - dsel=none, FSM=IDLE, err_count=0, err_addr=0.
//  - Hence HREADY=1, HRESP=0, HRDATA=0.
//  - Asserting reset mid-wait-state or mid-ERR1 aborts immediately, with no glitch beyond async clear.
//  Boundary conditions:
//  - New address presented during slave wait: ignored until HREADY=1, then must be re-presented by the master per AHB.
//  - Slave HRESP_S/HREADYOUT_S of non-selected slaves are ignored.
// TESTING
//  1. Reset: HRESETn=0 mid-transfer -> same cycle HREADY=1, HRESP=0, HRDATA=0, err_count=0.
//  2. Mapped read, N=4, slave1 base 0x0000_0000 mask 0x1000_0000:
//     NONSEQ HADDR=0x8000_0010, HRDATA_S[1]=0xCAFE_F00D -> HSEL=4'b0010; next cycle HRDATA=0xCAFE_F00D, HREADY=1.
//  3. Wait states: slave2 holds HREADYOUT_S[2]=0 for 3 cycles -> HREADY=0 for 3 cycles.
//     dsel is held while the next address targets slave0; slave0 data is returned afterwards.
//  4. Unmapped NONSEQ HADDR=0x1E00_0000 ->
//     - cycle+1: HREADY=0, HRESP=1.
//     - cycle+2: HREADY=1, HRESP=1.
//     - err_addr=0x1E00_0000, err_count=1.
//  5. Back-to-back unmapped accesses (second accepted in ERR2) -> ERR1 re-entered, err_count=2.
//     IDLE to an unmapped address -> OKAY, count unchanged.
//  6. Overlap: slave0 and slave2 both match 0x1F80_0000 -> HSEL selects slave0 only.
//     Counter preset to 0xFFFF plus one miss -> stays 0xFFFF.

Source files
------------

// File: rtl/mfp_ahb_interconnect.sv
// mfp_ahb_interconnect
// AHB-lite interconnect between the MIPS core master and N_SLAVES slaves.
// The address decode is combinational. The data-phase select is registered and
// drives the HRDATA/HREADY/HRESP return mux. A built-in default slave answers
// unmapped NONSEQ/SEQ transfers with a two-cycle ERROR. Decode misses are
// logged (saturating count and last address) for debug.
//
// Default-slave FSM
//   state   | meaning
//   DS_IDLE | no error response in progress
//   DS_ERR1 | first ERROR cycle: HREADY=0, HRESP=1
//   DS_ERR2 | second ERROR cycle: HREADY=1, HRESP=1
module mfp_ahb_interconnect #(
    parameter int                     N_SLAVES = 4,
    parameter logic [N_SLAVES*32-1:0] SLV_BASE = {N_SLAVES{32'h0}},
    parameter logic [N_SLAVES*32-1:0] SLV_MASK = {N_SLAVES{32'h0}},
    parameter int                     ERRCNT_W = 16
) (
    input  logic                     HCLK,
    input  logic                     HRESETn,
    input  logic [31:0]              HADDR,
    input  logic [1:0]               HTRANS,
    input  logic                     HWRITE,
    output logic [31:0]              HRDATA,
    output logic                     HREADY,
    output logic                     HRESP,
    output logic [N_SLAVES-1:0]      HSEL,
    input  logic [N_SLAVES*32-1:0]   HRDATA_S,
    input  logic [N_SLAVES-1:0]      HREADYOUT_S,
    input  logic [N_SLAVES-1:0]      HRESP_S,
    output logic [ERRCNT_W-1:0]      err_count,
    output logic [31:0]              err_addr
);

    typedef enum logic [1:0] {
        DS_IDLE = 2'd0,
        DS_ERR1 = 2'd1,
        DS_ERR2 = 2'd2
    } def_state_t;

    def_state_t            state;
    def_state_t            state_nxt;
    logic [N_SLAVES-1:0]   dec;
    logic                  dec_hit;
    logic [N_SLAVES-1:0]   sel_slv;
    logic                  sel_def;
    logic                  accept;
    logic                  miss_take;

    // The write flag and the SEQ/NONSEQ distinction do not affect routing.
    logic unused_bits;
    assign unused_bits = ^{HWRITE, HTRANS[0]};

    // Address decode: lowest-index match wins so HSEL is one-hot or zero.
    always_comb begin
        dec     = '0;
        dec_hit = 1'b0;
        for (int i = 0; i < N_SLAVES; i++) begin
            if (!dec_hit && ((HADDR & SLV_MASK[i*32 +: 32]) == SLV_BASE[i*32 +: 32])) begin
                dec[i]  = 1'b1;
                dec_hit = 1'b1;
            end
        end
    end

    assign HSEL      = dec;
    assign accept    = HREADY & HTRANS[1];
    assign miss_take = accept & ~dec_hit;

    // Data-phase select: follows the decode when a transfer completes, holds during waits.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            sel_slv <= '0;
            sel_def <= 1'b0;
        end else if (HREADY) begin
            if (HTRANS[1]) begin
                sel_slv <= dec;
                sel_def <= ~dec_hit;
            end else begin
                sel_slv <= '0;
                sel_def <= 1'b0;
            end
        end
    end

    // Default-slave state register.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state <= DS_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Default-slave next state: ERR1 is always followed by ERR2; ERR2 can chain into a new miss.
    always_comb begin
        state_nxt = state;
        case (state)
            DS_IDLE: if (miss_take) state_nxt = DS_ERR1;
            DS_ERR1: state_nxt = DS_ERR2;
            DS_ERR2: state_nxt = miss_take ? DS_ERR1 : DS_IDLE;
            default: state_nxt = DS_IDLE;
        endcase
    end

    // Return mux: nothing selected gives a zero-wait OKAY with zero data.
    always_comb begin
        HRDATA = '0;
        HREADY = 1'b1;
        HRESP  = 1'b0;
        if (sel_def) begin
            HREADY = (state != DS_ERR1);
            HRESP  = (state != DS_IDLE);
        end else begin
            for (int i = 0; i < N_SLAVES; i++) begin
                if (sel_slv[i]) begin
                    HRDATA = HRDATA_S[i*32 +: 32];
                    HREADY = HREADYOUT_S[i];
                    HRESP  = HRESP_S[i];
                end
            end
        end
    end

    // Miss log: capture the address and bump the saturating counter on every accepted miss.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            err_count <= '0;
            err_addr  <= '0;
        end else if (miss_take) begin
            err_addr <= HADDR;
            if (err_count != {ERRCNT_W{1'b1}}) begin
                err_count <= err_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mfp_ahb_interconnect.sv
// tb_mfp_ahb_interconnect
// Directed bench for the AHB-lite interconnect. Slaves are modelled as fixed
// read-data words with per-slave ready/response inputs. The miss counter is
// instantiated 4 bits wide so saturation is reached in a few dozen cycles.
module tb_mfp_ahb_interconnect;

    localparam int N = 4;
    localparam logic [N*32-1:0] BASE = {32'h1C00_0000, 32'h1F00_0000, 32'h0000_0000, 32'h1F80_0000};
    localparam logic [N*32-1:0] MASK = {32'hFF00_0000, 32'hFF00_0000, 32'h1000_0000, 32'hFFF0_0000};
    localparam logic [31:0] D0 = 32'h1111_0000;
    localparam logic [31:0] D1 = 32'hCAFE_F00D;
    localparam logic [31:0] D2 = 32'h2222_2222;
    localparam logic [31:0] D3 = 32'h3333_3333;
    localparam logic [1:0] T_IDLE   = 2'b00;
    localparam logic [1:0] T_BUSY   = 2'b01;
    localparam logic [1:0] T_NONSEQ = 2'b10;

    logic            HCLK = 1'b0;
    logic            HRESETn;
    logic [31:0]     HADDR;
    logic [1:0]      HTRANS;
    logic            HWRITE;
    logic [31:0]     HRDATA;
    logic            HREADY;
    logic            HRESP;
    logic [N-1:0]    HSEL;
    logic [N*32-1:0] HRDATA_S;
    logic [N-1:0]    HREADYOUT_S;
    logic [N-1:0]    HRESP_S;
    logic [3:0]      err_count;
    logic [31:0]     err_addr;

    int n_checks = 0;
    int n_errors = 0;

    mfp_ahb_interconnect #(
        .N_SLAVES (N),
        .SLV_BASE (BASE),
        .SLV_MASK (MASK),
        .ERRCNT_W (4)
    ) u_dut (
        .HCLK        (HCLK),
        .HRESETn     (HRESETn),
        .HADDR       (HADDR),
        .HTRANS      (HTRANS),
        .HWRITE      (HWRITE),
        .HRDATA      (HRDATA),
        .HREADY      (HREADY),
        .HRESP       (HRESP),
        .HSEL        (HSEL),
        .HRDATA_S    (HRDATA_S),
        .HREADYOUT_S (HREADYOUT_S),
        .HRESP_S     (HRESP_S),
        .err_count   (err_count),
        .err_addr    (err_addr)
    );

    always #5 HCLK = ~HCLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic cyc();
        @(posedge HCLK);
        #1;
    endtask

    task automatic drv(input logic [1:0] trans, input logic [31:0] addr);
        HTRANS = trans;
        HADDR  = addr;
        #1;
    endtask

    initial begin
        HRESETn     = 1'b0;
        HADDR       = 32'h0;
        HTRANS      = T_IDLE;
        HWRITE      = 1'b0;
        HRDATA_S    = {D3, D2, D1, D0};
        // slave3 is never addressed; its stuck-low ready and ERROR must be ignored
        HREADYOUT_S = 4'b0111;
        HRESP_S     = 4'b1000;
        cyc();
        cyc();
        chk("rst_hready", 32'(HREADY), 32'd1);
        chk("rst_hresp", 32'(HRESP), 32'd0);
        chk("rst_hrdata", HRDATA, 32'h0);
        chk("rst_errcnt", 32'(err_count), 32'd0);
        chk("rst_erraddr", err_addr, 32'h0);
        HRESETn = 1'b1;
        cyc();

        // mapped read to slave1
        drv(T_NONSEQ, 32'h8000_0010);
        chk("rd_hsel", 32'(HSEL), 32'h2);
        cyc();
        drv(T_IDLE, 32'h0);
        chk("rd_hrdata", HRDATA, D1);
        chk("rd_hready", 32'(HREADY), 32'd1);
        chk("rd_hresp", 32'(HRESP), 32'd0);
        cyc();
        chk("idle_hrdata", HRDATA, 32'h0);

        // slave2 with three wait states, next address to slave0 held off
        HREADYOUT_S[2] = 1'b0;
        drv(T_NONSEQ, 32'h1F10_0000);
        chk("ws_hsel", 32'(HSEL), 32'h4);
        cyc();
        drv(T_NONSEQ, 32'h1F80_0004);
        chk("ws_hsel_next", 32'(HSEL), 32'h1);
        chk("ws_wait1", 32'(HREADY), 32'd0);
        cyc();
        #1;
        chk("ws_wait2", 32'(HREADY), 32'd0);
        chk("ws_held_data", HRDATA, D2);
        cyc();
        #1;
        chk("ws_wait3", 32'(HREADY), 32'd0);
        HREADYOUT_S[2] = 1'b1;
        #1;
        chk("ws_done_ready", 32'(HREADY), 32'd1);
        chk("ws_done_data", HRDATA, D2);
        cyc();
        drv(T_IDLE, 32'h0);
        chk("ws_s0_data", HRDATA, D0);
        chk("ws_s0_ready", 32'(HREADY), 32'd1);
        cyc();

        // unmapped NONSEQ -> two-cycle ERROR
        drv(T_NONSEQ, 32'h1E00_0000);
        chk("um_hsel", 32'(HSEL), 32'h0);
        cyc();
        drv(T_IDLE, 32'h0);
        chk("err1_hready", 32'(HREADY), 32'd0);
        chk("err1_hresp", 32'(HRESP), 32'd1);
        chk("err1_hrdata", HRDATA, 32'h0);
        chk("err1_addr", err_addr, 32'h1E00_0000);
        chk("err1_count", 32'(err_count), 32'd1);
        cyc();
        #1;
        chk("err2_hready", 32'(HREADY), 32'd1);
        chk("err2_hresp", 32'(HRESP), 32'd1);
        cyc();
        #1;
        chk("post_err_hresp", 32'(HRESP), 32'd0);

        // back-to-back misses: the second is accepted in ERR2
        drv(T_NONSEQ, 32'h1E00_0100);
        cyc();
        drv(T_IDLE, 32'h0);
        cyc();
        drv(T_NONSEQ, 32'h1E00_0200);
        chk("b2b_err2_hresp", 32'(HRESP), 32'd1);
        cyc();
        drv(T_IDLE, 32'h0);
        chk("b2b_reerr1_hready", 32'(HREADY), 32'd0);
        chk("b2b_reerr1_hresp", 32'(HRESP), 32'd1);
        chk("b2b_count", 32'(err_count), 32'd3);
        chk("b2b_addr", err_addr, 32'h1E00_0200);
        cyc();
        // mapped read accepted during ERR2
        drv(T_NONSEQ, 32'h0000_0040);
        cyc();
        drv(T_IDLE, 32'h0);
        chk("err2_map_data", HRDATA, D1);
        chk("err2_map_resp", 32'(HRESP), 32'd0);
        chk("err2_map_ready", 32'(HREADY), 32'd1);
        cyc();

        // IDLE and BUSY to unmapped addresses: OKAY, no log
        drv(T_IDLE, 32'h1E00_0300);
        cyc();
        drv(T_BUSY, 32'h1E00_0400);
        chk("idle_um_resp", 32'(HRESP), 32'd0);
        cyc();
        drv(T_IDLE, 32'h0);
        chk("busy_um_ready", 32'(HREADY), 32'd1);
        chk("busy_um_resp", 32'(HRESP), 32'd0);
        chk("idle_um_count", 32'(err_count), 32'd3);

        // overlap: slave0 and slave2 both match, slave0 wins
        drv(T_IDLE, 32'h1F80_0000);
        chk("ovl_hsel", 32'(HSEL), 32'h1);

        // saturation: 12 more misses reach 15, one further miss holds at 15
        for (int k = 0; k < 12; k++) begin
            cyc();
            drv(T_NONSEQ, 32'h1E00_1000 + 32'(k));
            cyc();
            drv(T_IDLE, 32'h0);
        end
        cyc();
        cyc();
        chk("sat_reach", 32'(err_count), 32'd15);
        drv(T_NONSEQ, 32'h1E00_2000);
        cyc();
        drv(T_IDLE, 32'h0);
        chk("sat_hold", 32'(err_count), 32'd15);
        chk("sat_addr", err_addr, 32'h1E00_2000);
        cyc();
        cyc();

        // reset asserted during a slave wait state
        HREADYOUT_S[2] = 1'b0;
        drv(T_NONSEQ, 32'h1F10_0000);
        cyc();
        drv(T_IDLE, 32'h0);
        chk("rstw_pre_ready", 32'(HREADY), 32'd0);
        HRESETn = 1'b0;
        #1;
        chk("rstw_hready", 32'(HREADY), 32'd1);
        chk("rstw_hresp", 32'(HRESP), 32'd0);
        chk("rstw_hrdata", HRDATA, 32'h0);
        chk("rstw_count", 32'(err_count), 32'd0);
        HREADYOUT_S[2] = 1'b1;
        cyc();
        HRESETn = 1'b1;
        cyc();

        // reset asserted during ERR1
        drv(T_NONSEQ, 32'h1E00_0000);
        cyc();
        drv(T_IDLE, 32'h0);
        chk("rste_pre_resp", 32'(HRESP), 32'd1);
        HRESETn = 1'b0;
        #1;
        chk("rste_hready", 32'(HREADY), 32'd1);
        chk("rste_hresp", 32'(HRESP), 32'd0);
        chk("rste_count", 32'(err_count), 32'd0);
        chk("rste_addr", err_addr, 32'h0);
        cyc();
        HRESETn = 1'b1;
        cyc();
        #1;
        chk("rste_after_resp", 32'(HRESP), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
